// File: rtl/pll_rst_pkg.sv
// ---------------------------------------------------------------------------
// pll_rst_pkg
// Shared types and helpers for the PLL reset sequencer.
//  - state_t       : sequencer state encoding (2 bits)
//  - cycleCntWidth : width of the shared cycle counter, derived from the
//                    largest of the three cycle-count parameters
// No ports; imported by pll_reset_sequencer.
// ---------------------------------------------------------------------------
package pll_rst_pkg;

    typedef enum logic [1:0] {
        RESET_PLL = 2'd0,
        WAIT_LOCK = 2'd1,
        STABLE    = 2'd2,
        RUN       = 2'd3
    } state_t;

    // The counter only ever needs to hold (largest count - 1), so $clog2 of
    // the largest count is enough.  A floor of one bit keeps the vector legal
    // when every count parameter is 1.
    function automatic int cycleCntWidth(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (m < 2) return 1;
        return $clog2(m);
    endfunction

endpackage

// File: rtl/pll_reset_sequencer_sync_bit.sv
// ---------------------------------------------------------------------------
// sync_bit
// Multi-flop synchronizer for a single asynchronous level signal.
// Ports:
//  i_clk  in  1  destination clock
//  i_clr  in  1  asynchronous, active-high clear; all stages go to 0
//  i_d    in  1  asynchronous input level
//  o_q    out 1  synchronized level, STAGES destination edges behind i_d
// Parameter STAGES must be at least 2.
// ---------------------------------------------------------------------------
module sync_bit #(
    parameter int STAGES = 2
) (
    input  logic i_clk,
    input  logic i_clr,
    input  logic i_d,
    output logic o_q
);

    logic [STAGES-1:0] r_sync;

    // Plain shift chain: stage 0 may go metastable, the later stages give it
    // time to settle before anything downstream looks at the value.
    always_ff @(posedge i_clk or posedge i_clr) begin
        if (i_clr) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_d};
        end
    end

    assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/pll_reset_sequencer.sv
// ---------------------------------------------------------------------------
// pll_reset_sequencer
// Drives a PLL's reset, watches its asynchronous locked flag, and releases the
// core reset only once lock has been continuously stable.  Lock timeouts and
// lock losses re-reset the PLL and are counted in saturating status counters.
// Ports:
//  i_refclk      in   1      free-running reference clock (sole clock)
//  i_rst         in   1      asynchronous, active-high reset
//  i_pll_locked  in   1      PLL locked flag, asynchronous to i_refclk
//  o_pll_rst     out  1      reset to the PLL, active-high
//  o_sys_rst     out  1      core reset, active-high
//  o_ready       out  1      high only while running with stable lock
//  o_retry_cnt   out  CNT_W  lock timeouts seen, saturating
//  o_loss_cnt    out  CNT_W  lock losses seen while running, saturating
// ---------------------------------------------------------------------------
module pll_reset_sequencer
    import pll_rst_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int PLL_RST_CYCLES = 16,
    parameter int LOCK_TIMEOUT   = 65536,
    parameter int STABLE_CYCLES  = 1024,
    parameter int CNT_W          = 8
) (
    input  logic             i_refclk,
    input  logic             i_rst,
    input  logic             i_pll_locked,
    output logic             o_pll_rst,
    output logic             o_sys_rst,
    output logic             o_ready,
    output logic [CNT_W-1:0] o_retry_cnt,
    output logic [CNT_W-1:0] o_loss_cnt
);

    localparam int CYC_W = cycleCntWidth(PLL_RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);

    // Terminal values of the shared counter for each timed state.
    localparam logic [CYC_W-1:0] RST_LAST     = CYC_W'(PLL_RST_CYCLES - 1);
    localparam logic [CYC_W-1:0] TIMEOUT_LAST = CYC_W'(LOCK_TIMEOUT - 1);
    localparam logic [CYC_W-1:0] STABLE_LAST  = CYC_W'(STABLE_CYCLES - 1);
    localparam logic [CYC_W-1:0] CYC_ONE      = CYC_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

    state_t             r_state;
    state_t             w_nextState;
    logic [CYC_W-1:0]   r_cycleCnt;
    logic               w_lockedS;
    logic               w_retryHit;
    logic               w_lossHit;
    logic               r_pllRst;
    logic               r_sysRst;
    logic               r_ready;
    logic [CNT_W-1:0]   r_retryCnt;
    logic [CNT_W-1:0]   r_lossCnt;

    // The only place the raw locked flag enters this clock domain.
    sync_bit #(
        .STAGES (SYNC_STAGES)
    ) u_lockSync (
        .i_clk (i_refclk),
        .i_clr (i_rst),
        .i_d   (i_pll_locked),
        .o_q   (w_lockedS)
    );

    // Next-state decision.  A lock indication always wins over a timeout in
    // WAIT_LOCK, and any drop of lock while settling or running is acted on in
    // the very next edge.  The hit strobes tell the status counters which
    // transition is being taken.
    always_comb begin
        w_nextState = r_state;
        w_retryHit  = 1'b0;
        w_lossHit   = 1'b0;
        case (r_state)
            RESET_PLL: begin
                if (r_cycleCnt == RST_LAST) begin
                    w_nextState = WAIT_LOCK;
                end
            end
            WAIT_LOCK: begin
                if (w_lockedS) begin
                    w_nextState = STABLE;
                end else if (r_cycleCnt == TIMEOUT_LAST) begin
                    w_nextState = RESET_PLL;
                    w_retryHit  = 1'b1;
                end
            end
            STABLE: begin
                if (!w_lockedS) begin
                    w_nextState = WAIT_LOCK;
                end else if (r_cycleCnt == STABLE_LAST) begin
                    w_nextState = RUN;
                end
            end
            RUN: begin
                if (!w_lockedS) begin
                    w_nextState = RESET_PLL;
                    w_lossHit   = 1'b1;
                end
            end
            default: begin
                w_nextState = RESET_PLL;
            end
        endcase
    end

    // State register.
    always_ff @(posedge i_refclk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= RESET_PLL;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Shared cycle counter: restarts from zero on every state change so each
    // timed state measures its own dwell.  RUN has no time limit, so the
    // counter is frozen there instead of being allowed to wrap.
    always_ff @(posedge i_refclk or posedge i_rst) begin
        if (i_rst) begin
            r_cycleCnt <= '0;
        end else if (w_nextState != r_state) begin
            r_cycleCnt <= '0;
        end else if (r_state != RUN) begin
            r_cycleCnt <= r_cycleCnt + CYC_ONE;
        end
    end

    // Outputs are decoded from the state being entered and registered, so a
    // lock loss in RUN reasserts sys_rst on the same edge that leaves RUN.
    always_ff @(posedge i_refclk or posedge i_rst) begin
        if (i_rst) begin
            r_pllRst <= 1'b1;
            r_sysRst <= 1'b1;
            r_ready  <= 1'b0;
        end else begin
            r_pllRst <= (w_nextState == RESET_PLL);
            r_sysRst <= (w_nextState != RUN);
            r_ready  <= (w_nextState == RUN);
        end
    end

    // Status counters stick at all-ones rather than wrapping; only reset
    // clears them.
    always_ff @(posedge i_refclk or posedge i_rst) begin
        if (i_rst) begin
            r_retryCnt <= '0;
            r_lossCnt  <= '0;
        end else begin
            if (w_retryHit && (r_retryCnt != '1)) begin
                r_retryCnt <= r_retryCnt + CNT_ONE;
            end
            if (w_lossHit && (r_lossCnt != '1)) begin
                r_lossCnt <= r_lossCnt + CNT_ONE;
            end
        end
    end

    assign o_pll_rst   = r_pllRst;
    assign o_sys_rst   = r_sysRst;
    assign o_ready     = r_ready;
    assign o_retry_cnt = r_retryCnt;
    assign o_loss_cnt  = r_lossCnt;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// ---------------------------------------------------------------------------
// tb_pll_reset_sequencer
// Bench for pll_reset_sequencer with a shortened lock timeout and 2-bit
// status counters so that timeouts and saturation are reachable quickly.
// ---------------------------------------------------------------------------
module tb_pll_reset_sequencer;

    localparam int SYNC = 2;
    localparam int PRC  = 16;
    localparam int LT   = 100;
    localparam int SC   = 1024;
    localparam int CW   = 2;
    localparam int MAXC = (1 << CW) - 1;

    logic          refclk = 1'b0;
    logic          rst;
    logic          pllLocked = 1'b0;
    logic          pllRst;
    logic          sysRst;
    logic          ready;
    logic [CW-1:0] retryCnt;
    logic [CW-1:0] lossCnt;

    int vectors    = 0;
    int miscompares = 0;

    always #5 refclk = ~refclk;

    pll_reset_sequencer #(
        .SYNC_STAGES    (SYNC),
        .PLL_RST_CYCLES (PRC),
        .LOCK_TIMEOUT   (LT),
        .STABLE_CYCLES  (SC),
        .CNT_W          (CW)
    ) dut (
        .i_refclk     (refclk),
        .i_rst        (rst),
        .i_pll_locked (pllLocked),
        .o_pll_rst    (pllRst),
        .o_sys_rst    (sysRst),
        .o_ready      (ready),
        .o_retry_cnt  (retryCnt),
        .o_loss_cnt   (lossCnt)
    );

    // Behavioural reference: phases with entry timestamps, and a queue that
    // delays the locked flag by the synchronizer depth.  mEdge counts edges
    // since reset was released.
    int  mPhase = 0;
    int  mEdge  = 0;
    int  mEnter = 0;
    int  mRetry = 0;
    int  mLoss  = 0;
    int  mEl;
    bit  mLs;
    bit  mSyncQ[$];

    always @(posedge refclk or posedge rst) begin
        if (rst) begin
            mPhase = 0;
            mEdge  = 0;
            mEnter = 0;
            mRetry = 0;
            mLoss  = 0;
            mSyncQ.delete();
            for (int i = 0; i < SYNC; i++) mSyncQ.push_back(1'b0);
        end else begin
            mEdge = mEdge + 1;
            mLs   = mSyncQ.pop_front();
            mSyncQ.push_back(pllLocked);
            mEl   = mEdge - mEnter;
            case (mPhase)
                0: if (mEl >= PRC) begin mPhase = 1; mEnter = mEdge; end
                1: begin
                    if (mLs) begin
                        mPhase = 2; mEnter = mEdge;
                    end else if (mEl >= LT) begin
                        mPhase = 0; mEnter = mEdge;
                        if (mRetry < MAXC) mRetry = mRetry + 1;
                    end
                end
                2: begin
                    if (!mLs) begin
                        mPhase = 1; mEnter = mEdge;
                    end else if (mEl >= SC) begin
                        mPhase = 3; mEnter = mEdge;
                    end
                end
                3: if (!mLs) begin
                    mPhase = 0; mEnter = mEdge;
                    if (mLoss < MAXC) mLoss = mLoss + 1;
                end
                default: mPhase = 0;
            endcase
        end
    end

    logic [6:0] obsVec;
    logic [6:0] expVec;
    assign obsVec = {pllRst, sysRst, ready, retryCnt, lossCnt};
    assign expVec = {mPhase == 0, mPhase != 3, mPhase == 3, CW'(mRetry), CW'(mLoss)};

    // Drives a reset pulse and leaves the bench on the negedge where reset
    // was just released (mEdge == 0).
    task automatic applyStimulus();
        @(negedge refclk);
        pllLocked = 1'b0;
        #1 rst = 1'b1;
        repeat (3) @(negedge refclk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        pllLocked = 1'b0;
        repeat (3) begin
            @(negedge refclk);
            vectors++;
            if (obsVec !== 7'b1100000) begin
                miscompares++;
                $display("[TB] FAIL reset_values got=%b want=%b", obsVec, 7'b1100000);
            end
        end
        rst = 1'b0;
        while (mEdge < 24) begin
            @(negedge refclk);
            vectors++;
            if ({pllRst, sysRst, ready} !== {mEdge < PRC, 1'b1, 1'b0}) begin
                miscompares++;
                $display("[TB] FAIL reset_pulse edge=%0d got=%b want=%b", mEdge,
                         {pllRst, sysRst, ready}, {mEdge < PRC, 1'b1, 1'b0});
            end
        end
    endtask

    task automatic test_lock_sequence();
        int e;
        applyStimulus();
        while (mEdge < 1080) begin
            @(negedge refclk);
            e = mEdge;
            vectors++;
            if (obsVec !== expVec) begin
                miscompares++;
                $display("[TB] FAIL lock_model edge=%0d got=%b want=%b", e, obsVec, expVec);
            end
            vectors++;
            if ({pllRst, sysRst, ready} !== {e < PRC, e < 40 + SYNC + SC, e >= 40 + SYNC + SC}) begin
                miscompares++;
                $display("[TB] FAIL lock_timing edge=%0d got=%b want=%b", e, {pllRst, sysRst, ready},
                         {e < PRC, e < 40 + SYNC + SC, e >= 40 + SYNC + SC});
            end
            pllLocked = (e + 1 >= 40);
        end
        vectors++;
        if ({ready, retryCnt, lossCnt} !== 5'b10000) begin
            miscompares++;
            $display("[TB] FAIL lock_final got=%b want=%b", {ready, retryCnt, lossCnt}, 5'b10000);
        end
    endtask

    task automatic test_run_loss();
        int e;
        int d;
        d = mEdge + 10;
        while (mEdge < d + 1060) begin
            @(negedge refclk);
            e = mEdge;
            vectors++;
            if (obsVec !== expVec) begin
                miscompares++;
                $display("[TB] FAIL loss_model edge=%0d got=%b want=%b", e, obsVec, expVec);
            end
            if (e <= d + 40) begin
                vectors++;
                if ({pllRst, sysRst, ready, lossCnt} !==
                    {(e >= d + 2) && (e < d + 2 + PRC), e >= d + 2, e < d + 2, CW'(e >= d + 2)}) begin
                    miscompares++;
                    $display("[TB] FAIL loss_timing edge=%0d got=%b want=%b", e,
                             {pllRst, sysRst, ready, lossCnt},
                             {(e >= d + 2) && (e < d + 2 + PRC), e >= d + 2, e < d + 2, CW'(e >= d + 2)});
                end
            end
            pllLocked = (e + 1 != d);
        end
        vectors++;
        if ({ready, lossCnt} !== 3'b101) begin
            miscompares++;
            $display("[TB] FAIL loss_final got=%b want=%b", {ready, lossCnt}, 3'b101);
        end
    endtask

    task automatic test_async_reset(input string tag);
        @(negedge refclk);
        #2 rst = 1'b1;
        #1;
        vectors++;
        if (obsVec !== 7'b1100000) begin
            miscompares++;
            $display("[TB] FAIL async_%s got=%b want=%b", tag, obsVec, 7'b1100000);
        end
        pllLocked = 1'b0;
        repeat (2) @(negedge refclk);
        rst = 1'b0;
        while (mEdge < 24) begin
            @(negedge refclk);
            vectors++;
            if ((obsVec !== expVec) || (pllRst !== (mEdge < PRC))) begin
                miscompares++;
                $display("[TB] FAIL restart_%s edge=%0d got=%b want=%b", tag, mEdge, obsVec, expVec);
            end
        end
    endtask

    task automatic test_timeout_saturation();
        int e;
        int r;
        applyStimulus();
        while (mEdge < 6 * (PRC + LT) + 10) begin
            @(negedge refclk);
            e = mEdge;
            r = e / (PRC + LT);
            if (r > MAXC) r = MAXC;
            vectors++;
            if ({pllRst, sysRst, ready, retryCnt, lossCnt} !==
                {(e % (PRC + LT)) < PRC, 1'b1, 1'b0, CW'(r), CW'(0)}) begin
                miscompares++;
                $display("[TB] FAIL timeout edge=%0d got=%b want=%b", e,
                         {pllRst, sysRst, ready, retryCnt, lossCnt},
                         {(e % (PRC + LT)) < PRC, 1'b1, 1'b0, CW'(r), CW'(0)});
            end
            vectors++;
            if (obsVec !== expVec) begin
                miscompares++;
                $display("[TB] FAIL timeout_model edge=%0d got=%b want=%b", e, obsVec, expVec);
            end
        end
    endtask

    task automatic test_stable_glitch();
        int e;
        int n;
        applyStimulus();
        while (mEdge < 1560) begin
            @(negedge refclk);
            e = mEdge;
            vectors++;
            if ({sysRst, ready, retryCnt, lossCnt} !== {e < 525 + SYNC + SC, e >= 525 + SYNC + SC, 4'b0000}) begin
                miscompares++;
                $display("[TB] FAIL glitch edge=%0d got=%b want=%b", e, {sysRst, ready, retryCnt, lossCnt},
                         {e < 525 + SYNC + SC, e >= 525 + SYNC + SC, 4'b0000});
            end
            vectors++;
            if (obsVec !== expVec) begin
                miscompares++;
                $display("[TB] FAIL glitch_model edge=%0d got=%b want=%b", e, obsVec, expVec);
            end
            n = e + 1;
            pllLocked = (n >= 20) && !((n >= 522) && (n <= 524));
        end
    endtask

    task automatic test_stable_then_reset();
        applyStimulus();
        while (mEdge < 400) begin
            @(negedge refclk);
            vectors++;
            if (obsVec !== expVec) begin
                miscompares++;
                $display("[TB] FAIL prestable_model edge=%0d got=%b want=%b", mEdge, obsVec, expVec);
            end
            pllLocked = (mEdge + 1 >= 140);
        end
        vectors++;
        if ({sysRst, retryCnt} !== {1'b1, CW'(1)}) begin
            miscompares++;
            $display("[TB] FAIL prestable_state got=%b want=%b", {sysRst, retryCnt}, {1'b1, CW'(1)});
        end
        test_async_reset("stable");
    endtask

    task automatic test_random();
        int remaining;
        bit level;
        remaining = 0;
        level = 1'b0;
        applyStimulus();
        while (mEdge < 6000) begin
            @(negedge refclk);
            vectors++;
            if (obsVec !== expVec) begin
                miscompares++;
                $display("[TB] FAIL random_model edge=%0d got=%b want=%b", mEdge, obsVec, expVec);
            end
            if (remaining == 0) begin
                level = !level;
                if ($urandom_range(0, 3) == 0) remaining = int'($urandom_range(1, 6));
                else                           remaining = int'($urandom_range(20, 1300));
            end
            pllLocked = level;
            remaining--;
        end
    endtask

    initial begin
        rst = 1'b1;
        test_reset();
        test_lock_sequence();
        test_run_loss();
        test_async_reset("run");
        test_timeout_saturation();
        test_stable_glitch();
        test_stable_then_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
